mux_4_1_rr: RTL and testbench

- Four-channel-to-one merging multiplexer. It is the gather-side counterpart of the 1-to-4 demultiplexer (select S1:S0, enable En, outputs EnA..EnD).
- Four source channels (A, B, C, D) each present a valid/data/ready handshake.
- The block grants one channel per cycle in round-robin order and registers the word onto a single output channel.
- The output carries a 2-bit source tag, so a downstream demux can route the word back by that tag.

---
 rtl/mux_pkg.sv | 19 +
 rtl/rr_arbiter_4.sv | 40 ++++
 rtl/mux_4_1_rr.sv | 85 ++++++++
 tb/tb_mux_4_1_rr.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// +--------------------------------------------------------------------+
// | mux_pkg: channel tags shared by the 4:1 merge mux and its demux    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package mux_pkg;

  // Channel tags match the demux {S1,S0} select so words route back by tag.
  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  localparam int WIDTH_DEF = 8;

endpackage : mux_pkg

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// +--------------------------------------------------------------------+
// | rr_arbiter_4: combinational 4-way round-robin grant                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter_4
  import mux_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_ptr,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic       found;
  logic [1:0] idx;

  // Search begins one past the last winner and wraps, so last_ptr is lowest priority.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_ptr;
    found   = 1'b0;
    idx     = last_ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = last_ptr + 2'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule : rr_arbiter_4

`default_nettype wire

// File: rtl/mux_4_1_rr.sv
// +--------------------------------------------------------------------+
// | mux_4_1_rr: 4-to-1 round-robin merge with registered tagged output|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mux_4_1_rr
  import mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               En,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       last_ptr_q, last_ptr_d;

  logic       load_ok;
  logic       arb_en;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       accept;

  assign load_ok = !out_valid_q || out_ready;
  // Holding grants off during reset keeps in_ready quiet while rst_n is low.
  assign arb_en  = En && load_ok && rst_n;

  rr_arbiter_4 u_arb (
    .req      (in_valid),
    .last_ptr (last_ptr_q),
    .en       (arb_en),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign accept   = |gnt;
  assign in_ready = gnt;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    last_ptr_d  = last_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      last_ptr_d  = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= CH_A;
      last_ptr_q  <= CH_D;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      last_ptr_q  <= last_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule : mux_4_1_rr

`default_nettype wire

// File: tb/tb_mux_4_1_rr.sv
// +--------------------------------------------------------------------+
// | tb_mux_4_1_rr: directed self-checking bench for mux_4_1_rr         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mux_4_1_rr;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             En;
  logic [3:0]       in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]       in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic             out_ready;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mux_4_1_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .En        (En),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    rst_n     = 1'b0;
    En        = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};

    // 1. reset with all valid, then lone B
    cyc();
    cyc();
    chk_out("rst", 1'b0, 8'h00, 2'b00);
    chk("rst.ready", 32'(in_ready), 32'h0);
    rst_n    = 1'b1;
    in_valid = 4'b0010;
    in_data  = {8'h44, 8'h33, 8'h5A, 8'h11};
    #1;
    chk("b.ready", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("b.out", 1'b1, 8'h5A, 2'b01);

    // park last_ptr on D so saturation starts at A
    in_valid = 4'b1000;
    in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    #1;
    chk("d.ready", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("d.out", 1'b1, 8'h44, 2'b11);

    // 2. saturation: A,B,C,D,A,B,C,D
    in_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("sat%0d.ready", k), 32'(in_ready), 32'(1 << (k % 4)));
      cyc();
      chk_out($sformatf("sat%0d", k), 1'b1, 8'((k % 4 + 1) * 8'h11), 2'(k % 4));
    end

    // 3. hold C's word, then backpressure
    in_valid = 4'b0100;
    cyc();
    chk_out("c.out", 1'b1, 8'h33, 2'b10);
    in_valid  = 4'hF;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d.ready", k), 32'(in_ready), 32'h0);
      cyc();
      chk_out($sformatf("bp%0d", k), 1'b1, 8'h33, 2'b10);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.ready", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("bp.release", 1'b1, 8'h44, 2'b11);

    // 4. set last_ptr=A, then En=0 drain, then En=1 picks C
    in_valid = 4'b0001;
    cyc();
    chk_out("a.out", 1'b1, 8'h11, 2'b00);
    En       = 1'b0;
    in_valid = 4'b0101;
    #1;
    chk("en0.ready", 32'(in_ready), 32'h0);
    cyc();
    chk_out("en0.drain", 1'b0, 8'h11, 2'b00);
    #1;
    chk("en0.idle.ready", 32'(in_ready), 32'h0);
    cyc();
    chk("en0.idle.valid", 32'(out_valid), 32'h0);
    En = 1'b1;
    #1;
    chk("en1.ready", 32'(in_ready), 32'b0100);
    cyc();
    chk_out("en1.out", 1'b1, 8'h33, 2'b10);

    // 5. wrap with only B and D valid, last_ptr=D
    in_valid = 4'b1000;
    cyc();
    chk_out("wrap.d0", 1'b1, 8'h44, 2'b11);
    in_valid = 4'b1010;
    #1;
    chk("wrap1.ready", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("wrap1", 1'b1, 8'h22, 2'b01);
    #1;
    chk("wrap2.ready", 32'(in_ready), 32'b1000);
    cyc();
    chk_out("wrap2", 1'b1, 8'h44, 2'b11);
    #1;
    chk("wrap3.ready", 32'(in_ready), 32'b0010);
    cyc();
    chk_out("wrap3", 1'b1, 8'h22, 2'b01);

    // 6. reset while stalled with a held word
    in_valid  = 4'hF;
    out_ready = 1'b0;
    #1;
    chk("mid.ready", 32'(in_ready), 32'h0);
    rst_n = 1'b0;
    cyc();
    chk_out("mid.rst", 1'b0, 8'h00, 2'b00);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("post.ready", 32'(in_ready), 32'b0001);
    cyc();
    chk_out("post.out", 1'b1, 8'h11, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_mux_4_1_rr

`default_nettype wire
